// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port 64-bit memory between a read-only fetch port and a
// read/write data port, with fetch anti-starvation and out-of-range error responses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned MEM_DEPTH       = 1024,
  parameter int unsigned MEM_LAT         = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req_valid_i,
  input  logic              d_req_we_i,
  input  logic [63:0]       d_req_addr_i,
  input  logic [63:0]       d_req_wdata_i,
  output logic              d_req_ready_o,
  output logic              d_resp_valid_o,
  output logic [63:0]       d_resp_rdata_o,
  output logic              d_resp_err_o,
  input  logic              f_req_valid_i,
  input  logic [63:0]       f_req_addr_i,
  output logic              f_req_ready_o,
  output logic              f_resp_valid_o,
  output logic [63:0]       f_resp_rdata_o,
  output logic              f_resp_err_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  input  logic [63:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]   streak_q, streak_d;
  logic               owner_data_q;
  logic               we_q;

  logic               d_win, f_win, accept;
  logic [63:0]        acc_addr;
  logic               acc_oor;
  logic               resp_d, resp_owner_data, resp_err;
  logic [63:0]        resp_rdata;

  // Data wins unless it has used up its streak while fetch is waiting
  assign d_win    = d_req_valid_i &&
                    !((streak_q == CNT_W'(MAX_DATA_STREAK)) && f_req_valid_i);
  assign f_win    = f_req_valid_i && !d_win;
  assign accept   = (state_q == IDLE) && (d_win || f_win);
  assign acc_addr = d_win ? d_req_addr_i : f_req_addr_i;
  assign acc_oor  = acc_addr >= 64'(MEM_DEPTH);

  // Readies are forced low while reset is asserted so every output reads 0
  assign d_req_ready_o = (state_q == IDLE) && !rst && d_win;
  assign f_req_ready_o = (state_q == IDLE) && !rst && f_win;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (!f_req_valid_i || (accept && f_win)) begin
          streak_d = '0;
        end else if (accept && d_win && (streak_q < CNT_W'(MAX_DATA_STREAK))) begin
          streak_d = streak_q + CNT_W'(1);
        end
        if (accept) begin
          state_d = acc_oor ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q <= CNT_W'(1)) begin
          state_d = RESP;
        end else begin
          lat_d = lat_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      streak_q <= streak_d;
    end
  end

  // Response source: error straight from IDLE, or normal completion out of WAIT
  assign resp_d          = (state_d == RESP);
  assign resp_owner_data = (state_q == IDLE) ? d_win : owner_data_q;
  assign resp_err        = (state_q == IDLE);
  assign resp_rdata      = ((state_q == IDLE) || we_q) ? 64'h0 : mem_rdata_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_data_q   <= 1'b0;
      we_q           <= 1'b0;
      mem_en_o       <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      d_resp_valid_o <= 1'b0;
      d_resp_rdata_o <= '0;
      d_resp_err_o   <= 1'b0;
      f_resp_valid_o <= 1'b0;
      f_resp_rdata_o <= '0;
      f_resp_err_o   <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      if (accept) begin
        owner_data_q <= d_win;
        we_q         <= d_win && d_req_we_i;
      end
      mem_en_o    <= (state_d == ISSUE);
      mem_we_o    <= (state_d == ISSUE) && d_win && d_req_we_i;
      mem_addr_o  <= (state_d == ISSUE) ? acc_addr[ADDR_W-1:0] : '0;
      mem_wdata_o <= ((state_d == ISSUE) && d_win) ? d_req_wdata_i : 64'h0;
      d_resp_valid_o <= resp_d && resp_owner_data;
      f_resp_valid_o <= resp_d && !resp_owner_data;
      if (resp_d && resp_owner_data) begin
        d_resp_rdata_o <= resp_rdata;
        d_resp_err_o   <= resp_err;
      end
      if (resp_d && !resp_owner_data) begin
        f_resp_rdata_o <= resp_rdata;
        f_resp_err_o   <= resp_err;
      end
      busy_o <= (state_d != IDLE);
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 64-bit-word memory between the fetch requester (read-only) and the memory-stage requester (read/write).
- Memory-stage requests win by default. A streak counter prevents fetch starvation.
- Sequences each access through a fixed-latency memory, returns per-requester responses, and flags out-of-range addresses as memory errors.

Parameters:
ADDR_W, 10, width of mem_addr; word-address bits driven to memory
MEM_DEPTH, 1024, number of valid 64-bit words; addresses >= MEM_DEPTH are errors
MEM_LAT, 1, memory read latency in cycles (legal 1..15)
MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits (legal 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
d_req_valid  in  1  memory-stage request valid
d_req_we  in  1  1=write (rmmovq/call/pushq), 0=read (mrmovq/ret/popq)
d_req_addr  in  64  word address
d_req_wdata  in  64  write data (valA or valP)
d_req_ready  out  1  data request accepted this cycle when valid&ready
d_resp_valid  out  1  one-cycle data response pulse
d_resp_rdata  out  64  read data (valM); 0 on write or error
d_resp_err  out  1  address out of range
f_req_valid  in  1  fetch request valid
f_req_addr  in  64  word address
f_req_ready  out  1  fetch request accepted
f_resp_valid  out  1  one-cycle fetch response pulse
f_resp_rdata  out  64  instruction word; 0 on error
f_resp_err  out  1  address out of range
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  64  memory write data
mem_rdata  in  64  valid MEM_LAT cycles after the mem_en cycle
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Ready signals:
  - In IDLE, exactly one ready is asserted, combinationally, to the arbitration winner. Both readies are 0 in all other states.
  - Requesters hold valid and payload stable until accepted.
- Arbitration in IDLE:
  - Data wins if d_req_valid, unless streak == MAX_DATA_STREAK and f_req_valid, in which case fetch wins.
  - With only one valid requester, that requester wins.
- Streak counter:
  - Increments on a data grant while f_req_valid=1.
  - Clears on a fetch grant, or on any IDLE cycle with f_req_valid=0.
  - Saturates at MAX_DATA_STREAK.
- Accept at cycle T: latch owner, we, addr, wdata.
  - If addr >= MEM_DEPTH: go to RESP. Cycle T+1 gives owner's resp_valid=1, err=1, rdata=0, with no mem_en.
  - Otherwise go to ISSUE.
- ISSUE (T+1):
  - mem_en=1; mem_we=latched we (fetch always 0); mem_addr=addr[ADDR_W-1:0]; mem_wdata=latched wdata.
  - Load latency counter with MEM_LAT, then go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter reaches 1, register mem_rdata (read) or 0 (write), then go to RESP.
- RESP (T+2+MEM_LAT):
  - Owner's resp_valid=1 and err=0; the other port's response stays 0. Writes also pulse resp_valid as acknowledge.
  - Next state is IDLE. Outputs are registered, so a new accept can occur in the cycle after RESP at the earliest.
- Response payload: rdata/err hold their last value between pulses and are only meaningful with resp_valid. mem_we/mem_addr/mem_wdata are don't-care when mem_en=0, driven 0 here.
- Reset (asynchronous, any state, including mid-access): state=IDLE; all outputs 0; streak=0; the in-flight request is dropped with no response.
- Addresses compare as full 64-bit unsigned values; no truncation before the range check.

Test Plan:
- Data write then read, MEM_LAT=1. Write addr 10, data 64'h1234567890ABCDEF accepted at T → mem_en=1, mem_we=1 at T+1; d_resp_valid at T+3, err=0. Read addr 10 → d_resp_rdata=64'h1234567890ABCDEF.
- Simultaneous requests, d addr 10 read, f addr 20 → d_req_ready=1, f_req_ready=0. Data response is returned first, and fetch is accepted in the first IDLE cycle after it.
- Starvation, MAX_DATA_STREAK=4, both valid continuously → four data grants, then the fifth grant goes to fetch and the streak clears.
- Out of range, d_req_addr=64'h400 with MEM_DEPTH=1024 → no mem_en; d_resp_valid=1, d_resp_err=1, rdata=0 one cycle after accept. Same check with f_req_addr=64'hFFFFFFFFFFFFFFFF.
- Latency, MEM_LAT=3, fetch read addr 5 preloaded 64'hBBBBBBBBBBBBBBBB → f_resp_valid exactly 5 cycles after accept, rdata matches; busy=1 throughout.
- Reset pulse during WAIT → all outputs 0 immediately, no response for the dropped request. Next request after reset is served normally.
